// File: rtl/uart_conf_rx.sv
// uart_conf_rx: UART receiver that fills a checksummed, atomically committed parameter bank
// Ports:
//   clk       system clock
//   rst_n     synchronous active-low reset
//   uart_data asynchronous serial input, idle high
//   par_out   committed parameters, slice k = par_out[k*PAR_W +: PAR_W]
//   upd       one-cycle pulse when a packet with a good checksum commits
//   err_frame one-cycle pulse when a stop bit is sampled low
//   err_sum   one-cycle pulse on checksum mismatch
//   busy      high while a packet is partially received
module uart_conf_rx #(
  parameter int CLK_DIV = 16,
  parameter int N_PAR = 5,
  parameter int BYTES_PER_PAR = 1,
  parameter int PAR_W = 8,
  parameter int MSB_FIRST = 1,
  parameter int TIMEOUT_BITS = 20,
  parameter logic [N_PAR*PAR_W-1:0] PAR_RST = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     uart_data,
  output logic [N_PAR*PAR_W-1:0]   par_out,
  output logic                     upd,
  output logic                     err_frame,
  output logic                     err_sum,
  output logic                     busy
);
  localparam int NB = N_PAR * BYTES_PER_PAR;
  localparam int SW = NB * 8;
  localparam int TW = $clog2(CLK_DIV);
  localparam int BCW = $clog2(NB + 1);
  localparam int TO = TIMEOUT_BITS * CLK_DIV;
  localparam int ICW = $clog2(TO + 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
  state_t state, state_nx;
  logic s1, s2, s3;
  logic [TW-1:0] timer;
  logic [2:0] bit_cnt;
  logic [7:0] shreg, sum;
  logic [BCW-1:0] byte_cnt;
  logic [ICW-1:0] idle_cnt;
  logic [SW-1:0] shadow;
  logic [N_PAR*PAR_W-1:0] shadow_par;
  logic fall, tick, byte_done, frame_err, expire;

  assign fall = s3 & ~s2;
  assign tick = timer == '0;
  assign byte_done = state == STOP && tick && s2;
  assign frame_err = state == STOP && tick && !s2;
  assign expire = state == IDLE && byte_cnt != '0 && idle_cnt == ICW'(TO);
  assign busy = byte_cnt != '0 || !(state == IDLE || state == WAIT_HIGH);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (fall) state_nx = START;
      START:     if (tick) state_nx = s2 ? IDLE : DATA;
      DATA:      if (tick && bit_cnt == 3'd7) state_nx = STOP;
      STOP:      if (tick) state_nx = s2 ? IDLE : WAIT_HIGH;
      WAIT_HIGH: if (s2) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  // Bytes arrive big-endian and shift up, so the first parameter ends in the top slice.
  always_comb begin
    shadow_par = '0;
    for (int k = 0; k < N_PAR; k++) shadow_par[k*PAR_W +: PAR_W] = shadow[k*BYTES_PER_PAR*8 +: PAR_W];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      {s1, s2, s3} <= 3'b111;
      state <= IDLE;
      timer <= '0;
      bit_cnt <= '0;
      shreg <= '0;
      sum <= '0;
      byte_cnt <= '0;
      idle_cnt <= '0;
      shadow <= '0;
      par_out <= PAR_RST;
      upd <= 1'b0;
      err_sum <= 1'b0;
      err_frame <= 1'b0;
    end else begin
      {s1, s2, s3} <= {uart_data, s1, s2};
      state <= state_nx;
      // Half a bit to reach mid start bit, then whole bits from there on.
      timer <= (state == IDLE) ? TW'(CLK_DIV / 2 - 1) : tick ? TW'(CLK_DIV - 1) : timer - TW'(1);
      bit_cnt <= (state == DATA) ? bit_cnt + 3'(tick) : 3'd0;
      if (state == DATA && tick) shreg <= (MSB_FIRST != 0) ? {shreg[6:0], s2} : {s2, shreg[7:1]};
      idle_cnt <= (state != IDLE || fall || expire || byte_cnt == '0) ? '0 : idle_cnt + ICW'(1);
      upd <= 1'b0;
      err_sum <= 1'b0;
      err_frame <= frame_err;
      if (frame_err || expire) begin
        byte_cnt <= '0;
        sum <= '0;
      end else if (byte_done) begin
        if (byte_cnt == BCW'(NB)) begin
          byte_cnt <= '0;
          sum <= '0;
          if (shreg == sum) begin
            par_out <= shadow_par;
            upd <= 1'b1;
          end else err_sum <= 1'b1;
        end else begin
          byte_cnt <= byte_cnt + BCW'(1);
          sum <= sum + shreg;
          shadow <= (shadow << 8) | SW'(shreg);
        end
      end
    end
  end
endmodule

// File: tb/tb_uart_conf_rx.sv
// tb_uart_conf_rx: directed packets against a byte-level packet model plus literal expectations
module tb_uart_conf_rx;
  localparam int BT = 16;
  localparam int NP = 5;
  localparam int NBY = 5;
  logic clk, rst_n, line_d, line_w;
  logic [39:0] par_out;
  logic upd, err_frame, err_sum, busy;
  logic [23:0] par_out_w;
  logic upd_w, err_frame_w, err_sum_w, busy_w;
  int checks, fails;
  int pend, upd_cnt, esum_cnt, efr_cnt, w_upd, w_err;
  logic [39:0] model_par, pend_par;
  logic [7:0] mq[$];
  logic prev_busy;

  uart_conf_rx dut (
    .clk(clk), .rst_n(rst_n), .uart_data(line_d), .par_out(par_out),
    .upd(upd), .err_frame(err_frame), .err_sum(err_sum), .busy(busy)
  );

  uart_conf_rx #(.CLK_DIV(16), .N_PAR(2), .BYTES_PER_PAR(2), .PAR_W(12), .MSB_FIRST(0)) dutw (
    .clk(clk), .rst_n(rst_n), .uart_data(line_w), .par_out(par_out_w),
    .upd(upd_w), .err_frame(err_frame_w), .err_sum(err_sum_w), .busy(busy_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // pend: 0 nothing due, 1 commit, 2 checksum error, 3 frame error
  task automatic model_byte(input logic [7:0] b, input bit ok);
    int s;
    if (!ok) begin
      pend = 3;
      mq.delete();
    end else if (mq.size() == NBY) begin
      s = 0;
      foreach (mq[i]) s += int'(mq[i]);
      if (s % 256 == int'(b)) begin
        pend = 1;
        for (int k = 0; k < NP; k++) pend_par[k*8 +: 8] = mq[NP-1-k];
      end else pend = 2;
      mq.delete();
    end else mq.push_back(b);
  endtask

  task automatic model_reset();
    mq.delete();
    pend = 0;
    model_par = '0;
  endtask

  task automatic monitor();
    int n, ev;
    forever begin
      @(posedge clk);
      #1;
      n = int'(upd) + int'(err_sum) + int'(err_frame);
      if (n != 0) begin
        ev = upd ? 1 : err_sum ? 2 : 3;
        chk("event_kind", 64'(ev), 64'(pend));
        chk("pulse_excl", 64'(n), 64'd1);
        if (upd) begin
          chk("busy_fall", {62'd0, prev_busy, busy}, 64'd2);
          if (pend == 1) model_par = pend_par;
          upd_cnt++;
        end
        if (err_sum) esum_cnt++;
        if (err_frame) efr_cnt++;
        pend = 0;
      end
      chk("par_out", 64'(par_out), 64'(model_par));
      prev_busy = busy;
      if (upd_w) w_upd++;
      if (err_sum_w || err_frame_w) w_err++;
    end
  endtask

  task automatic set_line(input bit w, input logic v);
    if (w) line_w = v;
    else line_d = v;
  endtask

  task automatic wait_bt(input int n);
    repeat (n * BT) @(negedge clk);
  endtask

  task automatic send_byte(input bit w, input logic [7:0] b, input bit ok);
    set_line(w, 1'b0);
    wait_bt(1);
    for (int i = 0; i < 8; i++) begin
      set_line(w, w ? b[i] : b[7-i]);
      wait_bt(1);
    end
    if (!w) model_byte(b, ok);
    set_line(w, ok);
    wait_bt(1);
    if (!w) chk("event_due", 64'(pend), 64'd0);
    set_line(w, 1'b1);
  endtask

  task automatic send_pkt(input logic [47:0] v);
    for (int i = 0; i < 6; i++) send_byte(1'b0, v[47-8*i -: 8], 1'b1);
    wait_bt(2);
  endtask

  initial begin
    int u0, e0, f0;
    checks = 0; fails = 0; upd_cnt = 0; esum_cnt = 0; efr_cnt = 0; w_upd = 0; w_err = 0;
    prev_busy = 1'b0; pend_par = '0;
    rst_n = 1'b0; line_d = 1'b1; line_w = 1'b1;
    model_reset();
    fork monitor(); join_none
    repeat (5) @(negedge clk);
    chk("rst_flags", {60'd0, upd, err_sum, err_frame, busy}, 64'd0);
    chk("rst_par", 64'(par_out), 64'd0);
    chk("rst_par_w", 64'(par_out_w), 64'd0);
    rst_n = 1'b1;
    wait_bt(2);

    u0 = upd_cnt;
    send_pkt(48'hFE3CEA004064);
    chk("good_upd", 64'(upd_cnt - u0), 64'd1);
    chk("good_par", 64'(par_out), 64'hFE3CEA0040);
    chk("good_model", 64'(model_par), 64'hFE3CEA0040);

    u0 = upd_cnt; e0 = esum_cnt;
    send_pkt(48'hFE3CEA004065);
    chk("bad_sum_err", 64'(esum_cnt - e0), 64'd1);
    chk("bad_sum_noupd", 64'(upd_cnt - u0), 64'd0);
    chk("bad_sum_hold", 64'(par_out), 64'hFE3CEA0040);
    send_pkt(48'h1020304050F0);
    chk("after_bad_par", 64'(par_out), 64'h1020304050);

    u0 = upd_cnt; f0 = efr_cnt;
    send_byte(1'b0, 8'hFE, 1'b1);
    send_byte(1'b0, 8'h3C, 1'b1);
    send_byte(1'b0, 8'hEA, 1'b0);
    wait_bt(2);
    chk("frame_err", 64'(efr_cnt - f0), 64'd1);
    chk("frame_noupd", 64'(upd_cnt - u0), 64'd0);
    chk("frame_busy", 64'(busy), 64'd0);
    send_pkt(48'hFE3CEA004064);
    chk("after_frame_par", 64'(par_out), 64'hFE3CEA0040);

    u0 = upd_cnt;
    send_byte(1'b0, 8'hAA, 1'b1);
    send_byte(1'b0, 8'hBB, 1'b1);
    send_byte(1'b0, 8'hCC, 1'b1);
    repeat (4) @(negedge clk);
    chk("partial_busy", 64'(busy), 64'd1);
    wait_bt(25);
    mq.delete();
    chk("timeout_busy", 64'(busy), 64'd0);
    send_pkt(48'h01020304050F);
    chk("timeout_upd", 64'(upd_cnt - u0), 64'd1);
    chk("timeout_par", 64'(par_out), 64'h0102030405);

    e0 = esum_cnt; f0 = efr_cnt;
    line_d = 1'b0;
    repeat (3) @(negedge clk);
    line_d = 1'b1;
    wait_bt(2);
    chk("glitch_busy", 64'(busy), 64'd0);
    chk("glitch_err", 64'(esum_cnt - e0 + efr_cnt - f0), 64'd0);

    send_byte(1'b0, 8'h11, 1'b1);
    send_byte(1'b0, 8'h22, 1'b1);
    send_byte(1'b0, 8'h33, 1'b1);
    line_d = 1'b0;
    wait_bt(1);
    line_d = 1'b1;
    wait_bt(2);
    chk("mid_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("midrst_flags", {60'd0, upd, err_sum, err_frame, busy}, 64'd0);
    chk("midrst_par", 64'(par_out), 64'd0);
    rst_n = 1'b1;
    wait_bt(2);
    send_pkt(48'h1020304050F0);
    chk("after_rst_par", 64'(par_out), 64'h1020304050);

    send_byte(1'b1, 8'h0A, 1'b1);
    send_byte(1'b1, 8'hBC, 1'b1);
    send_byte(1'b1, 8'h01, 1'b1);
    send_byte(1'b1, 8'h23, 1'b1);
    send_byte(1'b1, 8'hEA, 1'b1);
    wait_bt(2);
    chk("wide_upd", 64'(w_upd), 64'd1);
    chk("wide_err", 64'(w_err), 64'd0);
    chk("wide_par", 64'(par_out_w), 64'hABC123);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/uart_conf_rx.md
# uart_conf_rx

Parametrised UART configuration receiver for the DRSSTC controller. It deserialises framed UART bytes from the host into a bank of `N_PAR` configuration parameters: reference generator, phase predictor, OCD level, interrupter frequency and interrupter pulse width in the default build. Each parameter is `PAR_W` bits wide and carried in `BYTES_PER_PAR` bytes. Every packet is checked by an 8-bit sum, and the whole bank is committed atomically, so downstream blocks never see a half-updated configuration.

## Interface
- `CLK_DIV`, 16: `clk` cycles per UART bit; must be ≥ 4.
- `N_PAR`, 5: number of parameters per packet.
- `BYTES_PER_PAR`, 1: bytes per parameter, big-endian (first byte is the MSB).
- `PAR_W`, 8: parameter width; must be ≤ 8·`BYTES_PER_PAR`. Upper received bits beyond `PAR_W` are discarded.
- `MSB_FIRST`, 1: bit order within a byte. 1 = MSB first (host tool default); 0 = LSB first (standard UART).
- `TIMEOUT_BITS`, 20: idle bit-times mid-packet before the partial packet is discarded.
- `PAR_RST`, 0: flat `N_PAR*PAR_W` reset value of the parameter bank.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `uart_data` in 1: asynchronous serial line, idle high.
- `par_out` out `N_PAR*PAR_W`: committed parameters; slice k = `par_out[k*PAR_W +: PAR_W]`.
- `upd` out 1: one-cycle pulse on commit.
- `err_frame` out 1: one-cycle pulse when a stop bit is sampled low.
- `err_sum` out 1: one-cycle pulse on checksum mismatch.
- `busy` out 1: high while a packet is partially received.

## Operation
- Input path: 2-flop synchroniser on `uart_data`; both flops reset to 1.
- Bit FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: a synchronised falling edge moves to START and loads the bit counter.
  - START: after `CLK_DIV/2` cycles, samples the line. Low moves to DATA. High is a false start and returns to IDLE with no error.
  - DATA: samples 8 bits, one every `CLK_DIV` cycles, and shifts them in per `MSB_FIRST`.
  - STOP: samples `CLK_DIV` cycles after the last data bit. High delivers the byte and returns to IDLE. Low pulses `err_frame`, discards the packet and moves to WAIT_HIGH.
  - WAIT_HIGH: waits for a synchronised high, then returns to IDLE.
- Packet layout: `N_PAR*BYTES_PER_PAR` data bytes, then 1 checksum byte.
- Data bytes go to a shadow bank. The first parameter received lands in the highest index (`N_PAR-1`); the last lands in index 0.
- Checksum: 8-bit sum mod 256 of all data bytes. On the checksum byte:
  - Match: shadow is copied to `par_out` and `upd` pulses.
  - Mismatch: `err_sum` pulses and `par_out` is unchanged.
  - Either way, the byte counter and running sum clear.
- Timeout: an idle counter counts cycles spent in IDLE while the byte count is > 0. When it reaches `TIMEOUT_BITS*CLK_DIV`, the byte counter and sum clear silently (no error pulse). The counter restarts on every start edge.
- `busy` = byte count ≠ 0, or FSM not in IDLE/WAIT_HIGH.
- A frame error discards the whole packet in progress: byte counter and sum clear.
- Counter widths: bit-timer `$clog2(CLK_DIV)`, byte counter `$clog2(N_PAR*BYTES_PER_PAR+1)`, idle counter `$clog2(TIMEOUT_BITS*CLK_DIV+1)`.

## Timing
- Reset (`rst_n` low at a `clk` edge):
  - `par_out` = `PAR_RST`.
  - `upd`, `err_frame`, `err_sum`, `busy` = 0.
  - FSM = IDLE, counters and sum = 0, shadow = 0.
- Reset mid-packet drops the partial packet; the next full packet after release is accepted normally.
- Start detection latency: 2 cycles (synchroniser) + 1 cycle (edge detect).
- Sample point: nominally mid-bit. Data bit n is sampled at `CLK_DIV/2 + (n+1)*CLK_DIV` cycles after the detected edge; stop is sampled at `CLK_DIV/2 + 9*CLK_DIV`.
- Commit: `par_out` and `upd` change in the cycle after the checksum byte's stop sample. `err_sum` uses the same cycle.
- `err_frame` asserts in the cycle after the failing stop sample.
- At most one of `upd`, `err_sum`, `err_frame` is high in any cycle.
- A new start edge is accepted from the cycle after a good stop sample, so back-to-back frames with one stop bit are supported.
- A start edge and a timeout expiry in the same cycle: the timeout wins, the byte counter clears, and the new byte is treated as byte 0.

## Test plan
- **Good packet** (defaults): send bytes FE, 3C, EA, 00, 40, then checksum 64. Required: exactly one `upd` pulse; `par_out` slices [4..0] = FE, 3C, EA, 00, 40; `busy` falls in the same cycle as `upd`.
- **Bad checksum**: same packet with checksum 65. Required: `err_sum` pulse, no `upd`, `par_out` holds its prior value; a following good packet commits.
- **Frame error**: stop bit of byte 2 forced low. Required: `err_frame` pulse, no `upd`; after the line returns high, a full good packet commits.
- **Timeout resync**: send 3 bytes, idle 25 bit-times, then a full good packet with values 01, 02, 03, 04, 05 and checksum 0F. Required: `upd` pulse, `par_out` = 01, 02, 03, 04, 05; the partial bytes are ignored.
- **Glitch and reset**:
  - A 3-cycle low pulse on an idle line: no `busy`, no error.
  - `rst_n` low during byte 3: all outputs return to reset values; the next packet commits.
- **Wide mode** (`BYTES_PER_PAR`=2, `PAR_W`=12, `N_PAR`=2, `MSB_FIRST`=0): send LSB-first bytes 0A, BC, 01, 23, then checksum EA. Required: `par_out` slices [1],[0] = ABC, 123.
